// File: rtl/dpram_sync.sv
// Dual-port byte-addressed RAM with registered reads on a data port and a fetch port.
// A clear FSM zero-fills the array after reset or on request and blocks both ports meanwhile.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_CLEAR | writing zero to word ptr_q each cycle; both ports dropped
//  ST_READY | array owned by the ports; clear_i starts a new zero-fill
module dpram_sync #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    output logic                      busy_o,
    input  logic                      ce_i,
    input  logic                      we_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic                      data_valid_o,
    output logic                      data_err_o,
    input  logic                      inst_ce_i,
    input  logic [ADDR_WIDTH-1:0]     pc_i,
    output logic [DATA_WIDTH-1:0]     inst_o,
    output logic                      inst_valid_o
);

    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int OFF     = $clog2(BYTES);
    localparam int WORD_AW = RAM_ADDR_WIDTH - OFF;
    localparam int DEPTH   = 2 ** WORD_AW;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_AW-1:0]  ptr_q, ptr_d;
    logic                clr_we;
    logic                port_en;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [WORD_AW-1:0]  d_idx, i_idx;
    logic                d_oor, i_oor;
    logic                d_wr;

    function automatic logic [WORD_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [RAM_ADDR_WIDTH-1:0] b;
        b = a[RAM_ADDR_WIDTH-1:0] >> OFF;
        return b[WORD_AW-1:0];
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> RAM_ADDR_WIDTH) != '0;
    endfunction

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == WORD_AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end
            end
            ST_READY: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy_o  = (state_q == ST_CLEAR);
        clr_we  = (state_q == ST_CLEAR);
        port_en = (state_q == ST_READY);
    end

    always_comb begin
        d_idx = word_idx(addr_i);
        i_idx = word_idx(pc_i);
        d_oor = out_of_range(addr_i);
        i_oor = out_of_range(pc_i);
        d_wr  = port_en && ce_i && we_i && !d_oor;
    end

    // Array writes; reads in the block below see the pre-edge contents (read-first).
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem[ptr_q] <= '0;
        end else if (d_wr) begin
            for (int i = 0; i < BYTES; i++) begin
                if (be_i[i]) begin
                    mem[d_idx][8*i +: 8] <= data_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            data_err_o   <= 1'b0;
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            data_err_o   <= 1'b0;
            inst_valid_o <= 1'b0;
            if (port_en && ce_i) begin
                data_err_o <= d_oor;
                if (!we_i) begin
                    data_valid_o <= 1'b1;
                    data_o       <= d_oor ? '0 : mem[d_idx];
                end
            end
            if (port_en && inst_ce_i) begin
                inst_valid_o <= 1'b1;
                inst_o       <= i_oor ? '0 : mem[i_idx];
            end
        end
    end

    // Debug byte access: address wraps modulo the decoded range, lane 0 is the MSB byte.
    function automatic logic [7:0] readByte(input logic [ADDR_WIDTH-1:0] a);
        int lane;
        lane = int'(a[RAM_ADDR_WIDTH-1:0]) % BYTES;
        return mem[word_idx(a)][DATA_WIDTH-1-8*lane -: 8];
    endfunction

    task automatic writeByte(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] v);
        int lane;
        lane = int'(a[RAM_ADDR_WIDTH-1:0]) % BYTES;
        mem[word_idx(a)][DATA_WIDTH-1-8*lane -: 8] <= v;
    endtask

endmodule
